coprocessor_pio_ctrl: RTL and testbench

Parametrised Avalon-MM PIO controller for driving coprocessor control lines from the Nios II, and for sampling coprocessor status lines. Output bits support atomic set/clear/toggle writes and per-bit auto-clearing pulse mode, driven by a shared retriggerable pulse counter. Input bits are synchronised, edge-captured and can raise a maskable interrupt. It replaces the fixed 3-bit write-only PIO in the Qsys system at the same slave position.

---
 rtl/coprocessor_pio_ctrl.sv | 166 ++++++++++++++++
 tb/tb_coprocessor_pio_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coprocessor_pio_ctrl.sv
// coprocessor_pio_ctrl: Avalon-MM PIO driving coprocessor control lines with set/clr/toggle and pulse mode,
//   and capturing edges on synchronised coprocessor status inputs behind a maskable level interrupt.
// Latency: writes update registers at the sampling edge; reads are combinational with zero wait states.
// Backpressure: none; the slave accepts every access in the cycle it is presented.
// Ports: clk/reset (sync, active high); address/chipselect/write_n/writedata/readdata (Avalon-MM slave);
//   in_port (async status inputs), out_port (registered control outputs), irq (level, active high).
module coprocessor_pio_ctrl #(
  parameter int unsigned               DATA_WIDTH   = 3,
  parameter int unsigned               IN_WIDTH     = 4,
  parameter logic [DATA_WIDTH-1:0]     RESET_VALUE  = '0,
  parameter int unsigned               PULSE_CYCLES = 4,
  parameter int unsigned               EDGE_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [IN_WIDTH-1:0]   in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES);

  localparam logic [2:0] A_DATA  = 3'd0;
  localparam logic [2:0] A_SET   = 3'd1;
  localparam logic [2:0] A_CLR   = 3'd2;
  localparam logic [2:0] A_TGL   = 3'd3;
  localparam logic [2:0] A_PMASK = 3'd4;
  localparam logic [2:0] A_IN    = 3'd5;
  localparam logic [2:0] A_EDGE  = 3'd6;
  localparam logic [2:0] A_IMASK = 3'd7;

  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] pmask_q, pmask_d;
  logic [IN_WIDTH-1:0]   edge_q, edge_d;
  logic [IN_WIDTH-1:0]   imask_q, imask_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]   sync1_q, sync1_d;
  logic [IN_WIDTH-1:0]   sync2_q, sync2_d;
  logic [IN_WIDTH-1:0]   prev_q, prev_d;

  logic                  wr;
  logic [DATA_WIDTH-1:0] wdat_out;
  logic [IN_WIDTH-1:0]   wdat_in;
  logic [DATA_WIDTH-1:0] out_wr;
  logic                  trig;
  logic                  expire;
  logic [IN_WIDTH-1:0]   det;
  logic [31:0]           rd_out;
  logic [31:0]           rd_in;

  // Only the low bits of writedata are meaningful; the rest is deliberately dropped.
  logic unused_wdat;
  assign unused_wdat = ^writedata;

  always_comb begin
    wr       = chipselect && !write_n;
    wdat_out = writedata[DATA_WIDTH-1:0];
    wdat_in  = writedata[IN_WIDTH-1:0];

    // Result of any DATA/SET/CLR/TGL write, before pulse expiry is considered.
    out_wr = out_q;
    if (wr) begin
      case (address)
        A_DATA:  out_wr = wdat_out;
        A_SET:   out_wr = out_q | wdat_out;
        A_CLR:   out_wr = out_q & ~wdat_out;
        A_TGL:   out_wr = out_q ^ wdat_out;
        default: out_wr = out_q;
      endcase
    end

    // CLR never triggers: it can only lower bits, so it cannot start a pulse.
    trig = wr && ((address == A_DATA) || (address == A_SET) || (address == A_TGL)) &&
           (|(out_wr & pmask_q));
    // A trigger landing on the last cycle wins over expiry and reloads instead.
    expire = (cnt_q == 16'd1) && !trig;

    out_d = out_wr;
    if (expire) begin
      out_d = out_wr & ~pmask_q;
    end

    cnt_d = cnt_q;
    if (trig) begin
      cnt_d = PULSE_LOAD;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end

    pmask_d = pmask_q;
    if (wr && (address == A_PMASK)) begin
      pmask_d = wdat_out;
    end

    imask_d = imask_q;
    if (wr && (address == A_IMASK)) begin
      imask_d = wdat_in;
    end

    sync1_d = in_port;
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    case (EDGE_MODE)
      0:       det = sync2_q & ~prev_q;
      1:       det = ~sync2_q & prev_q;
      default: det = sync2_q ^ prev_q;
    endcase

    // W1C first, then OR in new edges so a coincident edge survives the clear.
    edge_d = edge_q;
    if (wr && (address == A_EDGE)) begin
      edge_d = edge_q & ~wdat_in;
    end
    edge_d = edge_d | det;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= RESET_VALUE;
      pmask_q <= '0;
      edge_q  <= '0;
      imask_q <= '0;
      cnt_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      out_q   <= out_d;
      pmask_q <= pmask_d;
      edge_q  <= edge_d;
      imask_q <= imask_d;
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign out_port = out_q;
  assign irq      = |(edge_q & imask_q);

  // Zero-extended read mux; SET/CLR/TGL are write-only and read as zero.
  always_comb begin
    rd_out = '0;
    rd_in  = '0;
    case (address)
      A_DATA:  rd_out[DATA_WIDTH-1:0] = out_q;
      A_PMASK: rd_out[DATA_WIDTH-1:0] = pmask_q;
      A_IN:    rd_in[IN_WIDTH-1:0]    = sync2_q;
      A_EDGE:  rd_in[IN_WIDTH-1:0]    = edge_q;
      A_IMASK: rd_in[IN_WIDTH-1:0]    = imask_q;
      default: begin
        rd_out = '0;
        rd_in  = '0;
      end
    endcase
    readdata = rd_out | rd_in;
  end

endmodule

// File: tb/tb_coprocessor_pio_ctrl.sv
// tb_coprocessor_pio_ctrl: directed bench for coprocessor_pio_ctrl with hand-computed expectations.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked at the same offset.
// Backpressure: not applicable; the DUT slave never stalls.
module tb_coprocessor_pio_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic [2:0]  out_port;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  coprocessor_pio_ctrl #(
    .DATA_WIDTH  (3),
    .IN_WIDTH    (4),
    .RESET_VALUE (3'b101),
    .PULSE_CYCLES(4),
    .EDGE_MODE   (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .irq       (irq)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle write; returns 1 unit after the sampling edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic test_reset;
    logic [31:0] exp;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    n_cmp++;
    if (out_port !== 3'b101) begin
      $display("FAIL reset_out: got %b want 101", out_port); n_bad++;
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      $display("FAIL reset_irq: got %b want 0", irq); n_bad++;
    end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      exp = (a == 0) ? 32'd5 : 32'd0;
      n_cmp++;
      if (readdata !== exp) begin
        $display("FAIL reset_read[%0d]: got %h want %h", a, readdata, exp); n_bad++;
      end
    end
  endtask

  task automatic test_set_clr_tgl;
    logic [2:0] exp_o [3] = '{3'b111, 3'b110, 3'b001};
    logic [2:0] addr  [3] = '{3'd1, 3'd2, 3'd3};
    logic [2:0] dat   [3] = '{3'b010, 3'b001, 3'b111};
    for (int i = 0; i < 3; i++) begin
      wr(addr[i], {29'd0, dat[i]});
      n_cmp++;
      if (out_port !== exp_o[i]) begin
        $display("FAIL sct[%0d]: got %b want %b", i, out_port, exp_o[i]); n_bad++;
      end
      address = addr[i];
      #1;
      n_cmp++;
      if (readdata !== 32'd0) begin
        $display("FAIL sct_read[%0d]: got %h want 0", i, readdata); n_bad++;
      end
    end
    // Unused high bits are dropped and read back as zero.
    wr(3'd1, 32'hFFFF_FFF8);
    address = 3'd0;
    #1;
    n_cmp++;
    if (readdata !== 32'd1) begin
      $display("FAIL high_bits: got %h want 00000001", readdata); n_bad++;
    end
  endtask

  task automatic test_pulse;
    wr(3'd4, 32'd4);
    address = 3'd4;
    #1;
    n_cmp++;
    if (readdata !== 32'd4 || out_port !== 3'b001) begin
      $display("FAIL pmask_wr: got rd=%h out=%b want 4/001", readdata, out_port); n_bad++;
    end
    wr(3'd1, 32'd4);
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (out_port !== ((c < 4) ? 3'b101 : 3'b001)) begin
        $display("FAIL pulse[%0d]: got %b want %b", c, out_port, (c < 4) ? 3'b101 : 3'b001); n_bad++;
      end
      step(1);
    end
  endtask

  task automatic test_retrigger;
    wr(3'd1, 32'd4);
    step(1);
    wr(3'd1, 32'd4);
    // Bit high after edges E0..E5 (6 cycles); E0 and E1 already passed.
    for (int c = 2; c < 7; c++) begin
      n_cmp++;
      if (out_port[2] !== ((c < 6) ? 1'b1 : 1'b0)) begin
        $display("FAIL retrig[%0d]: got %b want %b", c, out_port[2], (c < 6)); n_bad++;
      end
      if (c < 6) step(1);
    end
  endtask

  task automatic test_back_to_back;
    wr(3'd1, 32'd4);
    step(3);
    wr(3'd1, 32'd4);   // sampled on the expiry edge
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (out_port !== ((c < 4) ? 3'b101 : 3'b001)) begin
        $display("FAIL wr_at_expiry[%0d]: got %b want %b", c, out_port, (c < 4) ? 3'b101 : 3'b001); n_bad++;
      end
      step(1);
    end
  endtask

  task automatic test_edge_irq;
    wr(3'd7, 32'd2);
    in_port = 4'b0010;
    step(2);
    address = 3'd6;
    #1;
    n_cmp++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      $display("FAIL edge_early: got edge=%h irq=%b want 0/0", readdata, irq); n_bad++;
    end
    step(1);
    address = 3'd6;
    #1;
    n_cmp++;
    if (readdata !== 32'd2 || irq !== 1'b1) begin
      $display("FAIL edge_set: got edge=%h irq=%b want 2/1", readdata, irq); n_bad++;
    end
    address = 3'd5;
    #1;
    n_cmp++;
    if (readdata !== 32'd2) begin
      $display("FAIL in_read: got %h want 2", readdata); n_bad++;
    end
    wr(3'd6, 32'd2);
    address = 3'd6;
    #1;
    n_cmp++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      $display("FAIL w1c: got edge=%h irq=%b want 0/0", readdata, irq); n_bad++;
    end
    in_port = 4'b0011;
    step(3);
    address = 3'd6;
    #1;
    n_cmp++;
    if (readdata !== 32'd1 || irq !== 1'b0) begin
      $display("FAIL unmasked_edge: got edge=%h irq=%b want 1/0", readdata, irq); n_bad++;
    end
    // Falling edge must not register in rising mode.
    in_port = 4'b0001;
    step(4);
    address = 3'd6;
    #1;
    n_cmp++;
    if (readdata !== 32'd1) begin
      $display("FAIL falling_ignored: got %h want 1", readdata); n_bad++;
    end
  endtask

  task automatic test_clear_collision;
    in_port = 4'b0011;
    step(2);
    wr(3'd6, 32'd2);   // W1C lands on the edge that captures bit 1
    address = 3'd6;
    #1;
    n_cmp++;
    if (readdata !== 32'd3 || irq !== 1'b1) begin
      $display("FAIL collision: got edge=%h irq=%b want 3/1", readdata, irq); n_bad++;
    end
  endtask

  task automatic test_reset_mid_pulse;
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd4);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_cmp++;
    if (out_port !== 3'b101 || irq !== 1'b0) begin
      $display("FAIL rst_mid: got out=%b irq=%b want 101/0", out_port, irq); n_bad++;
    end
    address = 3'd6;
    #1;
    n_cmp++;
    if (readdata !== 32'd0) begin
      $display("FAIL rst_edge: got %h want 0", readdata); n_bad++;
    end
    // Re-arm the mask: a stale counter would now clear bit 2.
    wr(3'd4, 32'd4);
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (out_port !== 3'b101) begin
        $display("FAIL rst_no_expiry[%0d]: got %b want 101", c, out_port); n_bad++;
      end
      step(1);
    end
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    #1;
    test_reset();
    test_set_clr_tgl();
    test_pulse();
    test_retrigger();
    test_back_to_back();
    test_edge_irq();
    test_clear_collision();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
